// File: rtl/traffic_pkg.sv
// Shared light encodings, FSM state type and field widths for the crossing light sequencer.
// Pure declarations; no latency or flow-control implications.
package traffic_pkg;

  localparam int SEC_W = 5;

  localparam logic [1:0] LIGHT_OFF    = 2'b00;
  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_YELLOW = 2'b11;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } state_t;

  function automatic logic [1:0] light_of(input state_t s);
    case (s)
      RED:     return LIGHT_RED;
      GREEN:   return LIGHT_GREEN;
      YELLOW:  return LIGHT_YELLOW;
      default: return LIGHT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV cycles; tick is high while count sits at TICK_DIV-1.
// enable=0 freezes the count and masks tick, so counting resumes where it stopped.
module tick_prescaler #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= at_last ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = enable && at_last;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Crossing light sequencer: RED -> GREEN -> YELLOW per 1 s tick, pedestrian request shortens GREEN.
// Outputs registered, one clk after the deciding tick; enable=0 freezes timing but still latches requests.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = 10_000_000,
  parameter int RED_SEC       = 10,
  parameter int GREEN_SEC     = 10,
  parameter int YELLOW_SEC    = 2,
  parameter int MIN_GREEN_SEC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn,
  output logic [1:0] lights,
  output logic       walk,
  output logic       tick,
  output logic       phase_done
);

  localparam logic [SEC_W-1:0] RED_LAST       = SEC_W'(RED_SEC - 1);
  localparam logic [SEC_W-1:0] GREEN_LAST     = SEC_W'(GREEN_SEC - 1);
  localparam logic [SEC_W-1:0] YELLOW_LAST    = SEC_W'(YELLOW_SEC - 1);
  localparam logic [SEC_W-1:0] MIN_GREEN_LAST = SEC_W'(MIN_GREEN_SEC - 1);

  state_t           state, state_nxt;
  logic [SEC_W-1:0] sec, sec_nxt;
  logic             ped_req, ped_nxt;
  logic             btn_meta, btn_sync, btn_prev, btn_edge;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // Synchroniser and edge detector keep running while disabled so presses are never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign btn_edge = btn_sync & ~btn_prev;

  always_comb begin
    state_nxt = state;
    sec_nxt   = sec;
    ped_nxt   = ped_req;

    if (btn_edge && (state == GREEN || state == YELLOW)) begin
      ped_nxt = 1'b1;
    end

    if (tick) begin
      case (state)
        INIT: begin
          state_nxt = RED;
          sec_nxt   = '0;
        end
        RED: begin
          if (sec == RED_LAST) begin
            state_nxt = GREEN;
            sec_nxt   = '0;
          end else begin
            sec_nxt = sec + SEC_W'(1);
          end
        end
        GREEN: begin
          // Exit test uses the registered request, so a same-tick edge waits one tick.
          if (sec == GREEN_LAST || (ped_req && sec >= MIN_GREEN_LAST)) begin
            state_nxt = YELLOW;
            sec_nxt   = '0;
          end else begin
            sec_nxt = sec + SEC_W'(1);
          end
        end
        YELLOW: begin
          if (sec == YELLOW_LAST) begin
            state_nxt = RED;
            sec_nxt   = '0;
            ped_nxt   = 1'b0;
          end else begin
            sec_nxt = sec + SEC_W'(1);
          end
        end
        default: begin
          state_nxt = INIT;
          sec_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      sec        <= '0;
      ped_req    <= 1'b0;
      lights     <= LIGHT_OFF;
      walk       <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sec        <= sec_nxt;
      ped_req    <= ped_nxt;
      lights     <= light_of(state_nxt);
      walk       <= (state_nxt == RED);
      phase_done <= (state_nxt != state);
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus pushes expected phase events, a negedge monitor pops them on phase_done.
module tb_traffic_phase_scheduler;

  localparam int TDIV = 4;
  localparam logic [1:0] L_OFF = 2'b00;
  localparam logic [1:0] L_RED = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_YEL = 2'b11;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b1;
  logic       btn    = 1'b0;
  logic [1:0] lights;
  logic       walk;
  logic       tick;
  logic       phase_done;

  traffic_phase_scheduler #(
    .TICK_DIV(TDIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .btn        (btn),
    .lights     (lights),
    .walk       (walk),
    .tick       (tick),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  // gap = clk cycles the previous phase lasted (first event: cycle number after reset release)
  typedef struct packed {
    logic [1:0]  l;
    logic        w;
    logic [15:0] gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 1;
  int   last_pd = 0;

  always @(posedge clk) begin
    if (reset) cyc = 1;
    else       cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      last_pd = 0;
    end else if (phase_done) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL phase_unexpected: got lights=%b walk=%b gap=%0d, required no phase change",
                 lights, walk, cyc - last_pd);
      end else begin
        mon_e = exp_q.pop_front();
        if (lights !== mon_e.l || walk !== mon_e.w || (cyc - last_pd) != int'(mon_e.gap)) begin
          n_bad = n_bad + 1;
          $display("FAIL phase_event: got lights=%b walk=%b gap=%0d, required lights=%b walk=%b gap=%0d",
                   lights, walk, cyc - last_pd, mon_e.l, mon_e.w, mon_e.gap);
        end
      end
      last_pd = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] l, input logic w, input int gap);
    exp_q.push_back({l, w, 16'(gap)});
  endtask

  task automatic wait_phase(input logic [1:0] l);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(phase_done && lights == l) && k < 300);
    if (k >= 300) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL wait_phase_timeout: got no phase_done for lights=%b, required one within 300 cycles", l);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;

    // Test 1: reset state, first tick and RED entry timing
    repeat (3) @(negedge clk);
    check("rst_lights", 32'(lights), 32'(L_OFF));
    check("rst_walk", 32'(walk), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_phase_done", 32'(phase_done), 0);

    push(L_RED, 1'b1, 5);
    // Test 2: three undisturbed cycles
    for (int i = 0; i < 3; i++) begin
      push(L_GRN, 1'b0, 40);
      push(L_YEL, 1'b0, 40);
      push(L_RED, 1'b1, 8);
    end
    reset = 1'b0;

    k = 0;
    while (!tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_tick_cycle", 32'(cyc), 4);

    // Test 3: button at GREEN sec=1 shortens GREEN to 3 ticks
    push(L_GRN, 1'b0, 40);
    push(L_YEL, 1'b0, 12);
    push(L_RED, 1'b1, 8);
    repeat (4) wait_phase(L_GRN);
    repeat (4) @(posedge clk);
    #1 btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 btn = 1'b0;

    // Test 4: button pressed in RED and held gives no request
    push(L_GRN, 1'b0, 40);
    push(L_YEL, 1'b0, 40);
    push(L_RED, 1'b1, 8);
    wait_phase(L_RED);
    check("walk_in_red", 32'(walk), 1);
    repeat (8) @(posedge clk);
    #1 btn = 1'b1;
    wait_phase(L_YEL);
    btn = 1'b0;

    // Test 5: 20-cycle pause at GREEN sec=4
    push(L_GRN, 1'b0, 40);
    push(L_YEL, 1'b0, 60);
    wait_phase(L_GRN);
    repeat (17) @(posedge clk);
    #1 enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pause_lights", 32'(lights), 32'(L_GRN));
      check("pause_tick", 32'(tick), 0);
    end
    @(posedge clk);
    #1 enable = 1'b1;

    // Test 6: asynchronous reset mid-YELLOW, then restart
    wait_phase(L_YEL);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_lights", 32'(lights), 32'(L_OFF));
    check("async_rst_walk", 32'(walk), 0);
    check("async_rst_phase_done", 32'(phase_done), 0);
    push(L_RED, 1'b1, 5);
    push(L_GRN, 1'b0, 40);
    push(L_YEL, 1'b0, 40);
    push(L_RED, 1'b1, 8);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
